// File: rtl/sum_accum_stage.sv
// rtl/sum_accum_stage.sv - accumulates COUNT sums into a saturated block total with valid/ready handshakes
module sum_accum_stage #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 9,
    parameter int COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(COUNT) + 1;

    typedef enum logic {S_ACCUM, S_HOLD} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_total;
    logic               r_out_ovf;

    logic               w_xfer;
    logic               w_last;
    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_next;

    // One extra bit of headroom exposes the carry that triggers saturation.
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
    assign w_sat      = w_sum[ACC_W];
    assign w_acc_next = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_ovf_next = r_ovf | w_sat;
    assign w_xfer     = in_valid & (r_state == S_ACCUM);
    assign w_last     = (r_cnt == CNT_W'(COUNT - 1));

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = r_out_valid;
    assign out_total = r_out_total;
    assign out_ovf   = r_out_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_total <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_state     <= S_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_total <= w_acc_next;
                            r_out_ovf   <= w_ovf_next;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                        end else begin
                            r_acc <= w_acc_next;
                            r_ovf <= w_ovf_next;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_ACCUM;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accum_stage.sv
// tb/tb_sum_accum_stage.sv - model-checked bench driving a 9-bit and an 8-bit accumulator in lockstep
module tb_sum_accum_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_sum = '0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [8:0] out_total_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [7:0] out_total_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accum_stage #(.SUM_W(5), .ACC_W(9), .COUNT(16)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_total(out_total_a), .out_ovf(out_ovf_a)
    );

    sum_accum_stage #(.SUM_W(5), .ACC_W(8), .COUNT(16)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_total(out_total_b), .out_ovf(out_ovf_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a block is just the plain integer sum of 16 accepted samples, clipped to the width.
    int m_n = 0;
    int m_sum = 0;
    int m_tot = 0;
    bit m_hold = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_n = 0;
            m_sum = 0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_sum = m_sum + int'(in_sum);
            m_n = m_n + 1;
            if (m_n == 16) begin
                m_tot = m_sum;
                m_hold = 1'b1;
                m_n = 0;
                m_sum = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_in_ready", int'(in_ready_a), int'(!m_hold));
            chk("a_out_valid", int'(out_valid_a), int'(m_hold));
            chk("b_in_ready", int'(in_ready_b), int'(!m_hold));
            chk("b_out_valid", int'(out_valid_b), int'(m_hold));
            if (m_hold) begin
                chk("a_total", int'(out_total_a), (m_tot > 511) ? 511 : m_tot);
                chk("a_ovf", int'(out_ovf_a), int'(m_tot > 511));
                chk("b_total", int'(out_total_b), (m_tot > 255) ? 255 : m_tot);
                chk("b_ovf", int'(out_ovf_b), int'(m_tot > 255));
            end
        end
    end

    task automatic send(input int v);
        int  k = 0;
        bit  ok;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum = 5'(v);
            ok = in_ready_a;
            @(posedge clk);
            k++;
        end while (!ok && k < 50);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
    endtask

    // Called straight after the final transfer edge: result must already be visible.
    task automatic wait_result(input int ta, input int oa, input int tb, input int ob, input int hold);
        @(negedge clk);
        in_valid = 1'b1;
        in_sum = 5'd7;
        chk("lit_valid_latency", int'(out_valid_a), 1);
        chk("lit_a_total", int'(out_total_a), ta);
        chk("lit_a_ovf", int'(out_ovf_a), oa);
        chk("lit_b_total", int'(out_total_b), tb);
        chk("lit_b_ovf", int'(out_ovf_b), ob);
        chk("lit_hold_in_ready", int'(in_ready_a), 0);
        repeat (hold) @(negedge clk);
        chk("lit_hold_total", int'(out_total_a), ta);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("lit_ready_after_hs", int'(in_ready_a), 1);
        chk("lit_valid_after_hs", int'(out_valid_a), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_total", int'(out_total_a), 0);
        chk("rst_out_ovf", int'(out_ovf_b), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) send(3);
        wait_result(48, 0, 48, 0, 0);
        release_result();

        for (int i = 0; i < 16; i++) send(i);
        wait_result(120, 0, 120, 0, 5);
        release_result();

        for (int i = 0; i < 16; i++) send(31);
        wait_result(496, 0, 255, 1, 0);
        release_result();
        for (int i = 0; i < 16; i++) send(1);
        wait_result(16, 0, 16, 0, 0);
        release_result();

        for (int i = 0; i < 16; i++) begin
            send(31);
            if (i != 15) bubble();
        end
        wait_result(496, 0, 255, 1, 0);
        release_result();

        for (int i = 0; i < 7; i++) send(5);
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_sum = 5'd5;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("lit_clear_in_ready", int'(in_ready_a), 1);
        for (int i = 0; i < 16; i++) send(2);
        wait_result(32, 0, 32, 0, 1);
        clear = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("lit_clear_hold_valid", int'(out_valid_a), 0);
        chk("lit_clear_hold_ready", int'(in_ready_a), 1);

        for (int i = 0; i < 16; i++) send(1);
        wait_result(16, 0, 16, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("lit_async_rst_hold", int'(out_valid_a), 0);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) send(4);
        #2 rst = 1'b1;
        #1 chk("lit_async_rst_mid", int'(in_ready_a), 1);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) send(1);
        wait_result(16, 0, 16, 0, 2);
        release_result();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
